// File: rtl/stage_sequencer_mc.sv
// stage_sequencer_mc
//   Multicycle stage sequencer. Walks each instruction through IF/ID/EX/MEM/RW,
//   choosing the path from insType/func, and drives registered one-hot stage
//   enables to the datapath. Supports stall, flush, a memory-ready handshake
//   with optional MEM timeout, and a one-cycle instruction-retire pulse.
//
//   Ports:
//     clock        rising-edge clock
//     reset_n      asynchronous active-low reset
//     stall        hold current stage (lower priority than flush)
//     flush        abort current instruction, restart at IF
//     mem_ready    data memory done, sampled only in MEM
//     insType      decoded instruction type
//     func         decoded function field
//     IF..RW       registered one-hot stage enables (none in BOOT)
//     instr_done   1-cycle pulse in the IF cycle after a normal retire
//     mem_timeout  sticky flag: a MEM access was aborted on timeout
//     stage        state code (BOOT=7, IF=0, ID=1, EX=2, MEM=3, RW=4)
//
//   Optional build macro SEQ_PERF_CNT_EN adds retired_cnt and cycle_cnt
//   performance counters (CNT_W bits, wrapping).
module stage_sequencer_mc #(
    parameter int                FUNC_W      = 5,
    parameter int                TYPE_W      = 2,
    parameter logic [TYPE_W-1:0] T_R         = 2'b00,
    parameter logic [TYPE_W-1:0] T_I         = 2'b01,
    parameter logic [TYPE_W-1:0] T_J         = 2'b10,
    parameter logic [FUNC_W-1:0] F_RCMP      = 3,
    parameter logic [FUNC_W-1:0] F_LOAD      = 2,
    parameter logic [FUNC_W-1:0] F_STORE     = 3,
    parameter logic [FUNC_W-1:0] F_BRANCH    = 4,
    parameter logic [FUNC_W-1:0] F_JUMP      = 0,
    parameter int                TMO_W       = 4,
    parameter int                MEM_TIMEOUT = 15
`ifdef SEQ_PERF_CNT_EN
    ,
    parameter int                CNT_W       = 32
`endif
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_ready,
    input  logic [TYPE_W-1:0] insType,
    input  logic [FUNC_W-1:0] func,
    output logic              IF,
    output logic              ID,
    output logic              EX,
    output logic              MEM,
    output logic              RW,
    output logic              instr_done,
    output logic              mem_timeout,
    output logic [2:0]        stage
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  retired_cnt,
    output logic [CNT_W-1:0]  cycle_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_RW   = 3'd4,
        S_BOOT = 3'd7
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LAST =
        TMO_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [TMO_W-1:0] wait_q, wait_d;
    logic             done_d;
    logic             tmo_d;

    logic is_r, is_i, is_j;
    assign is_r = (insType == T_R);
    assign is_i = (insType == T_I);
    assign is_j = (insType == T_J);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
        if (state_q == S_BOOT) begin
            state_d = S_IF;
        end else if (flush) begin
            state_d = S_IF;
            wait_d  = '0;
        end else if (stall) begin
            state_d = state_q;
        end else begin
            case (state_q)
                S_IF: state_d = S_ID;
                S_ID: begin
                    if (is_j && func == F_JUMP) begin
                        state_d = S_IF;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_EX;
                    end
                end
                S_EX: begin
                    if (is_j || (is_i && func == F_BRANCH) || (is_r && func == F_RCMP)) begin
                        state_d = S_IF;
                        done_d  = 1'b1;
                    end else if (is_i && (func == F_LOAD || func == F_STORE)) begin
                        state_d = S_MEM;
                    end else begin
                        state_d = S_RW;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        wait_d = '0;
                        if (func == F_LOAD) begin
                            state_d = S_RW;
                        end else begin
                            state_d = S_IF;
                            done_d  = 1'b1;
                        end
                    end else if (MEM_TIMEOUT != 0 && wait_q == TMO_LAST) begin
                        state_d = S_IF;
                        wait_d  = '0;
                        tmo_d   = 1'b1;
                    end else if (wait_q != '1) begin
                        // saturates when no timeout is configured
                        wait_d = wait_q + 1'b1;
                    end
                end
                S_RW: begin
                    state_d = S_IF;
                    done_d  = 1'b1;
                end
                default: state_d = S_IF;
            endcase
        end
    end

    // Enables are decoded from the next state so they line up with state_q.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_BOOT;
            wait_q      <= '0;
            IF          <= 1'b0;
            ID          <= 1'b0;
            EX          <= 1'b0;
            MEM         <= 1'b0;
            RW          <= 1'b0;
            instr_done  <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            IF          <= (state_d == S_IF);
            ID          <= (state_d == S_ID);
            EX          <= (state_d == S_EX);
            MEM         <= (state_d == S_MEM);
            RW          <= (state_d == S_RW);
            instr_done  <= done_d;
            mem_timeout <= mem_timeout | tmo_d;
        end
    end

    assign stage = state_q;

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            retired_cnt <= '0;
            cycle_cnt   <= '0;
        end else begin
            if (done_d) begin
                retired_cnt <= retired_cnt + 1'b1;
            end
            if (state_q != S_BOOT) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stage_sequencer_mc.sv
module tb_stage_sequencer_mc;

    logic       clock;
    logic       reset_n;
    logic       stall, flush, mem_ready;
    logic [1:0] insType;
    logic [4:0] func;
    logic       IF, ID, EX, MEM, RW;
    logic       instr_done, mem_timeout;
    logic [2:0] stage;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] retired_cnt, cycle_cnt;
`endif

    stage_sequencer_mc #(.MEM_TIMEOUT(15)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .stall       (stall),
        .flush       (flush),
        .mem_ready   (mem_ready),
        .insType     (insType),
        .func        (func),
        .IF          (IF),
        .ID          (ID),
        .EX          (EX),
        .MEM         (MEM),
        .RW          (RW),
        .instr_done  (instr_done),
        .mem_timeout (mem_timeout),
        .stage       (stage)
`ifdef SEQ_PERF_CNT_EN
        ,
        .retired_cnt (retired_cnt),
        .cycle_cnt   (cycle_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       stall;
        logic       flush;
        logic       rdy;
        logic [1:0] typ;
        logic [4:0] fn;
        logic [2:0] exp_stage;
        logic       exp_done;
        logic       exp_tmo;
    } vec_t;

    vec_t vecs[$];
    int   nvec = 0;
    int   nerr = 0;

    function automatic vec_t mk(input logic s, input logic f, input logic r,
                                input logic [1:0] t, input logic [4:0] fn,
                                input logic [2:0] es, input logic ed, input logic et);
        vec_t v;
        v.stall = s; v.flush = f; v.rdy = r; v.typ = t; v.fn = fn;
        v.exp_stage = es; v.exp_done = ed; v.exp_tmo = et;
        return v;
    endfunction

    function automatic logic [4:0] onehot(input logic [2:0] s);
        case (s)
            3'd0:    return 5'b10000;
            3'd1:    return 5'b01000;
            3'd2:    return 5'b00100;
            3'd3:    return 5'b00010;
            3'd4:    return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    task automatic cmp(input string name, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] es,
                             input logic ed, input logic et);
        cmp({tag, ".stage"}, int'(stage), int'(es));
        cmp({tag, ".en"}, int'({IF, ID, EX, MEM, RW}), int'(onehot(es)));
        cmp({tag, ".done"}, int'(instr_done), int'(ed));
        cmp({tag, ".tmo"}, int'(mem_timeout), int'(et));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic s, input logic f, input logic r,
                         input logic [1:0] t, input logic [4:0] fn);
        stall = s; flush = f; mem_ready = r; insType = t; func = fn;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        #2;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        int mem_cycles;

        reset_n = 1'b0;
        drive(0, 0, 0, 2'b00, 5'd1);

        // stall/flush ignored on the BOOT edge; R-type ALU path then jump,
        // branch, load with 3 wait cycles, stall in EX, stall+flush, etc.
        //              st fl rdy typ    fn   stage done tmo
        vecs.push_back(mk(1, 1, 0, 2'b00, 5'd1, 3'd0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2'b00, 5'd1, 3'd1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2'b00, 5'd1, 3'd2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2'b00, 5'd1, 3'd4, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2'b00, 5'd1, 3'd0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 2'b10, 5'd0, 3'd1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2'b10, 5'd0, 3'd0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 2'b01, 5'd4, 3'd1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2'b01, 5'd4, 3'd2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2'b01, 5'd4, 3'd0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 2'b01, 5'd2, 3'd1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2'b01, 5'd2, 3'd2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2'b01, 5'd2, 3'd3, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2'b01, 5'd2, 3'd3, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2'b01, 5'd2, 3'd3, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2'b01, 5'd2, 3'd3, 0, 0));
        vecs.push_back(mk(0, 0, 1, 2'b01, 5'd2, 3'd4, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2'b01, 5'd2, 3'd0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 2'b00, 5'd1, 3'd1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2'b00, 5'd1, 3'd2, 0, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 0, 0, 2'b00, 5'd1, 3'd2, 0, 0));
        vecs.push_back(mk(1, 1, 0, 2'b00, 5'd1, 3'd0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'b00, 5'd1, 3'd0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2'b00, 5'd3, 3'd1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2'b00, 5'd3, 3'd2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2'b00, 5'd3, 3'd0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 2'b00, 5'd3, 3'd0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2'b11, 5'd0, 3'd1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2'b11, 5'd0, 3'd2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2'b11, 5'd0, 3'd4, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2'b11, 5'd0, 3'd0, 1, 0));

        #12;
        check_all("reset", 3'd7, 0, 0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].stall, vecs[i].flush, vecs[i].rdy, vecs[i].typ, vecs[i].fn);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].exp_stage,
                      vecs[i].exp_done, vecs[i].exp_tmo);
        end

        // Store with memory never ready: 15 MEM cycles, then abort to IF.
        drive(0, 0, 0, 2'b01, 5'd3);
        tick();
        tick();
        tick();
        mem_cycles = 0;
        for (int i = 0; i < 40 && stage == 3'd3; i++) begin
            mem_cycles++;
            tick();
        end
        cmp("tmo.mem_cycles", mem_cycles, 15);
        check_all("tmo.exit", 3'd0, 0, 1);

        // Jump after the timeout: retires normally, timeout stays sticky.
        drive(0, 0, 0, 2'b10, 5'd0);
        tick();
        check_all("sticky.id", 3'd1, 0, 1);
        tick();
        check_all("sticky.if", 3'd0, 1, 1);

        // Async reset asserted between edges while waiting in MEM.
        drive(0, 0, 0, 2'b01, 5'd2);
        tick();
        tick();
        tick();
        tick();
        cmp("arst.pre_stage", int'(stage), 3);
        #3;
        reset_n = 1'b0;
        #1;
        check_all("arst.now", 3'd7, 0, 0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        check_all("arst.boot_exit", 3'd0, 0, 0);

`ifdef SEQ_PERF_CNT_EN
        do_reset();
        drive(0, 0, 0, 2'b00, 5'd1);
        tick();
        for (int i = 0; i < 4000; i++) tick();
        cmp("perf.retired", int'(retired_cnt), 1000);
        cmp("perf.cycles", int'(cycle_cnt), 4000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
